spc7110_rom_arbiter: RTL and testbench
======================================

# spc7110_rom_arbiter

Time-multiplexes the single external ROM/SRAM port between SNES bus accesses (already translated to a ROM_ADDR by the address decoder) and SPC7110 coprocessor fetches: DCU compressed-data reads and data-port reads from banked DROM. SNES accesses have priority, and the coprocessor is guaranteed forward progress. The block sits between the address decoder / SPC7110 core and the memory pin drivers.

## Interface
- ACC_CYCLES, 6: CLK cycles per memory window; legal range is 3 to 15.
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- SNES_RD_REQ  in  1  one-cycle pulse requesting a SNES read; edge detection is done upstream.
- SNES_WR_REQ  in  1  one-cycle pulse requesting a SNES write.
- SNES_ROM_ADDR  in  24  translated address, sampled with the request.
- SNES_WR_DATA  in  8  write data, sampled with the request.
- SNES_RD_DATA  out  8  last SNES read result.
- SNES_BUSY  out  1  a SNES access is pending or in flight.
- SNES_OVERRUN  out  1  sticky; a SNES request arrived while one was already pending.
- DCU_REQ  in  1  level; held until DCU_ACK.
- DCU_ADDR  in  24  held stable while DCU_REQ is high.
- DCU_DATA  out  8  fetched byte.
- DCU_ACK  out  1  one-cycle pulse; DCU_DATA is valid in the same cycle.
- MEM_ADDR  out  24  memory address.
- MEM_DOUT  out  8  write data.
- MEM_DIN  in  8  read data.
- MEM_OE_N  out  1  output enable, active low.
- MEM_WE_N  out  1  write enable, active low.
- MEM_DRIVE  out  1  enable for the data bus output buffer.

## Operation
- States: IDLE, SNES_RD, SNES_WR, DCU_RD.
- A window counter counts 0 to ACC_CYCLES-1 inside each non-IDLE state.
- SNES request latch:
  - One entry holding {rd/wr, addr, data}.
  - Loaded on any SNES_*_REQ pulse, in any state.
  - A load while the latch is already full overwrites the entry and sets SNES_OVERRUN.
  - If RD and WR pulse together, WR wins.
- Grant decision is taken in IDLE, or on the last window cycle (counter = ACC_CYCLES-1):
  - SNES pending and DCU_REQ low: grant SNES.
  - DCU_REQ high and SNES not pending: grant DCU.
  - Both pending: grant DCU if the `dcu_starved` flag is set, otherwise grant SNES.
  - `dcu_starved` is set when a SNES grant is issued while DCU_REQ is high, and cleared on every DCU grant. Under contention the two requesters therefore alternate.
  - Nothing pending: go to IDLE.
- The SNES latch clears when its window is granted, so a new pulse during that window is accepted without raising OVERRUN.
- Reads:
  - MEM_OE_N is low for the whole window.
  - MEM_DIN is sampled on the last window cycle.
- Writes:
  - MEM_DRIVE is high for the whole window.
  - MEM_WE_N is low on counter values 1 to ACC_CYCLES-2, giving one cycle of setup and one of hold.
- DCU_REQ dropping mid-window is a protocol violation. The window completes, DCU_ACK still pulses, and `dcu_starved` clears.
- SNES_BUSY = latch full OR state is SNES_RD/SNES_WR.

## Timing
- Reset values:
  - State IDLE, counter 0, latch empty, `dcu_starved` 0.
  - SNES_OVERRUN 0, SNES_BUSY 0, DCU_ACK 0.
  - SNES_RD_DATA and DCU_DATA 0x00.
  - MEM_ADDR 0, MEM_DOUT 0, MEM_OE_N 1, MEM_WE_N 1, MEM_DRIVE 0.
- All outputs are registered.
- Request at cycle n from IDLE: the window occupies cycles n+1 to n+ACC_CYCLES.
- Read data:
  - SNES_RD_DATA updates at cycle n+ACC_CYCLES+1.
  - DCU_ACK pulses at cycle n+ACC_CYCLES+1.
- Windows run back-to-back with no idle gap.
- Worst-case SNES latency is 2·ACC_CYCLES+1 cycles, i.e. one DCU window ahead of it.
- Reset asserted mid-window drops all strobes on the asynchronous edge; no ACK is issued.

## Structure
- Shared package `spc7110_pkg` holds:
  - the state enum;
  - `ACC_CYCLES_MAX` = 15;
  - the request-kind encoding (RD/WR).
- Natural sub-module: `rom_req_latch`, the one-entry SNES request holder with overwrite and overrun flag.
- Everything else lives in the top module.

## Test plan
- Idle SNES read of 0x123456 with MEM_DIN = 0xA5 → MEM_OE_N is low for 6 cycles with MEM_ADDR = 0x123456, and SNES_RD_DATA = 0xA5 seven cycles after the pulse.
- SNES write of 0x3C to 0xE00010 → MEM_DRIVE is high for 6 cycles, MEM_WE_N is low for exactly 4 cycles (counter 1 to 4), and MEM_DOUT = 0x3C.
- DCU_REQ and SNES_RD_REQ together in IDLE → SNES window first, then the DCU window back-to-back; DCU_ACK comes 13 cycles after the requests.
- DCU_REQ held high while SNES pulses every 6 cycles → grants alternate SNES, DCU, SNES, DCU…; no DCU wait exceeds 12 cycles.
- Two SNES pulses during one DCU window → SNES_OVERRUN goes to 1, and only the second address is accessed.
- RST pulsed in the 3rd cycle of a DCU window → all outputs return to their reset values immediately; no DCU_ACK is issued; a DCU_REQ still held after reset is re-granted.

Source files
------------

// File: rtl/spc7110_pkg.sv
// Shared definitions for the SPC7110 external ROM port arbiter.
package spc7110_pkg;

    localparam int ACC_CYCLES_MAX = 15;
    localparam int CNT_W          = $clog2(ACC_CYCLES_MAX + 1);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_SNES_RD = 2'd1;
    localparam state_t ST_SNES_WR = 2'd2;
    localparam state_t ST_DCU_RD  = 2'd3;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_t;

    typedef struct packed {
        req_kind_t   kind;
        logic [23:0] addr;
        logic [7:0]  data;
    } snes_req_t;

    function automatic logic is_snes_state(input state_t s);
        return (s == ST_SNES_RD) || (s == ST_SNES_WR);
    endfunction

endpackage

// File: rtl/rom_req_latch.sv
// One-entry SNES request holder; a new pulse overwrites the entry, and a
// pulse arriving while it is still full raises a sticky overrun flag.
module rom_req_latch
    import spc7110_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [23:0] addr,
    input  logic [7:0]  wr_data,
    input  logic        take,
    output logic        eff_valid,
    output snes_req_t   eff_req,
    output logic        full_next,
    output logic        overrun
);

    snes_req_t entry_reg;
    logic      full_reg;
    logic      load;
    snes_req_t incoming;

    // The effective view includes a same-cycle pulse so an idle arbiter can
    // grant it without first parking it in the latch.
    always_comb begin
        load          = rd_req | wr_req;
        incoming.kind = wr_req ? REQ_WR : REQ_RD;
        incoming.addr = addr;
        incoming.data = wr_data;
        eff_valid     = load | full_reg;
        eff_req       = load ? incoming : entry_reg;
        full_next     = eff_valid & ~take;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_reg <= '0;
            full_reg  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                entry_reg <= incoming;
            end
            full_reg <= full_next;
            if (load && full_reg) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spc7110_rom_arbiter.sv
// Shares the external ROM/SRAM port between SNES accesses and SPC7110 DCU
// fetches in fixed-length windows; SNES first, DCU guaranteed to alternate.
module spc7110_rom_arbiter
    import spc7110_pkg::*;
#(
    parameter int ACC_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snes_rd_req,
    input  logic        snes_wr_req,
    input  logic [23:0] snes_rom_addr,
    input  logic [7:0]  snes_wr_data,
    output logic [7:0]  snes_rd_data,
    output logic        snes_busy,
    output logic        snes_overrun,
    input  logic        dcu_req,
    input  logic [23:0] dcu_addr,
    output logic [7:0]  dcu_data,
    output logic        dcu_ack,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_drive
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(ACC_CYCLES - 2);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             starved_reg, starved_next;

    logic      window_end;
    logic      decide;
    logic      dcu_pend;
    logic      grant_snes;
    logic      grant_dcu;
    logic      eff_valid;
    snes_req_t eff_req;
    logic      latch_full_next;

    rom_req_latch u_req_latch (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (snes_rd_req),
        .wr_req    (snes_wr_req),
        .addr      (snes_rom_addr),
        .wr_data   (snes_wr_data),
        .take      (grant_snes),
        .eff_valid (eff_valid),
        .eff_req   (eff_req),
        .full_next (latch_full_next),
        .overrun   (snes_overrun)
    );

    // DCU_REQ is still high while its own window finishes and during the ACK
    // cycle; it must not count as a fresh request then.
    always_comb begin
        window_end   = (state_reg != ST_IDLE) && (cnt_reg == CNT_LAST);
        decide       = (state_reg == ST_IDLE) || window_end;
        dcu_pend     = dcu_req && !dcu_ack && (state_reg != ST_DCU_RD);
        grant_snes   = decide && eff_valid && (!dcu_pend || !starved_reg);
        grant_dcu    = decide && dcu_pend && !grant_snes;

        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        starved_next = starved_reg;

        if (decide) begin
            cnt_next = '0;
            if (grant_snes) begin
                state_next = (eff_req.kind == REQ_WR) ? ST_SNES_WR : ST_SNES_RD;
                if (dcu_req) begin
                    starved_next = 1'b1;
                end
            end else if (grant_dcu) begin
                state_next   = ST_DCU_RD;
                starved_next = 1'b0;
            end else begin
                state_next = ST_IDLE;
            end
        end
    end

    // Strobes are registered from the next state/counter so each window's
    // pins line up exactly with the window's own cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            starved_reg  <= 1'b0;
            snes_rd_data <= 8'h00;
            snes_busy    <= 1'b0;
            dcu_data     <= 8'h00;
            dcu_ack      <= 1'b0;
            mem_addr     <= 24'h000000;
            mem_dout     <= 8'h00;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            mem_drive    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            starved_reg <= starved_next;

            dcu_ack <= window_end && (state_reg == ST_DCU_RD);
            if (window_end && (state_reg == ST_DCU_RD)) begin
                dcu_data <= mem_din;
            end
            if (window_end && (state_reg == ST_SNES_RD)) begin
                snes_rd_data <= mem_din;
            end

            if (grant_snes) begin
                mem_addr <= eff_req.addr;
                if (eff_req.kind == REQ_WR) begin
                    mem_dout <= eff_req.data;
                end
            end else if (grant_dcu) begin
                mem_addr <= dcu_addr;
            end

            mem_oe_n  <= !((state_next == ST_SNES_RD) || (state_next == ST_DCU_RD));
            mem_drive <= (state_next == ST_SNES_WR);
            mem_we_n  <= !((state_next == ST_SNES_WR) && (cnt_next != '0) &&
                           (cnt_next <= WE_LAST));
            snes_busy <= latch_full_next || is_snes_state(state_next);
        end
    end

endmodule

// File: tb/tb_spc7110_rom_arbiter.sv
// Directed bench for spc7110_rom_arbiter with ACC_CYCLES = 6.
module tb_spc7110_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snes_rd_req = 1'b0;
    logic        snes_wr_req = 1'b0;
    logic [23:0] snes_rom_addr = '0;
    logic [7:0]  snes_wr_data = '0;
    logic [7:0]  snes_rd_data;
    logic        snes_busy;
    logic        snes_overrun;
    logic        dcu_req = 1'b0;
    logic [23:0] dcu_addr = '0;
    logic [7:0]  dcu_data;
    logic        dcu_ack;
    logic [23:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic        mem_drive;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spc7110_rom_arbiter #(.ACC_CYCLES(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .snes_rd_req   (snes_rd_req),
        .snes_wr_req   (snes_wr_req),
        .snes_rom_addr (snes_rom_addr),
        .snes_wr_data  (snes_wr_data),
        .snes_rd_data  (snes_rd_data),
        .snes_busy     (snes_busy),
        .snes_overrun  (snes_overrun),
        .dcu_req       (dcu_req),
        .dcu_addr      (dcu_addr),
        .dcu_data      (dcu_data),
        .dcu_ack       (dcu_ack),
        .mem_addr      (mem_addr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .mem_oe_n      (mem_oe_n),
        .mem_we_n      (mem_we_n),
        .mem_drive     (mem_drive)
    );

    // Cycle c begins 1 ns after a rising edge; inputs are set and outputs read there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        snes_rd_req = 1'b0; snes_wr_req = 1'b0; snes_rom_addr = '0; snes_wr_data = '0;
        dcu_req = 1'b0; dcu_addr = '0; mem_din = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_oe_n, mem_we_n, mem_drive, snes_busy, snes_overrun, dcu_ack} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_strobes got %b exp 110000",
                     {mem_oe_n, mem_we_n, mem_drive, snes_busy, snes_overrun, dcu_ack});
        end
        checks++;
        if ({mem_addr, mem_dout, snes_rd_data, dcu_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {mem_addr, mem_dout, snes_rd_data, dcu_data});
        end
        $display("test_reset done");
    endtask

    task automatic test_snes_read();
        int oe_cnt = 0;
        do_reset();
        snes_rd_req = 1'b1; snes_rom_addr = 24'h123456;
        step();
        snes_rd_req = 1'b0; snes_rom_addr = '0;
        for (int c = 1; c <= 8; c++) begin
            mem_din = (c == 6) ? 8'hA5 : 8'h00;
            if (!mem_oe_n) begin
                oe_cnt++;
                checks++;
                if (mem_addr !== 24'h123456) begin
                    errors++;
                    $display("FAIL rd_addr cycle %0d got %h exp 123456", c, mem_addr);
                end
            end
            if (c == 1) begin
                checks++;
                if (snes_busy !== 1'b1) begin
                    errors++; $display("FAIL rd_busy_on got %b exp 1", snes_busy);
                end
            end
            if (c == 6) begin
                checks++;
                if (snes_rd_data !== 8'h00) begin
                    errors++; $display("FAIL rd_data_early got %h exp 00", snes_rd_data);
                end
            end
            if (c == 7) begin
                checks++;
                if (snes_rd_data !== 8'hA5) begin
                    errors++; $display("FAIL rd_data got %h exp a5", snes_rd_data);
                end
                checks++;
                if (snes_busy !== 1'b0) begin
                    errors++; $display("FAIL rd_busy_off got %b exp 0", snes_busy);
                end
            end
            step();
        end
        checks++;
        if (oe_cnt != 6) begin
            errors++; $display("FAIL rd_oe_len got %0d exp 6", oe_cnt);
        end
        $display("test_snes_read: oe cycles %0d data %h", oe_cnt, snes_rd_data);
    endtask

    task automatic test_snes_write();
        int drv_cnt = 0;
        int we_cnt = 0;
        int oe_cnt = 0;
        do_reset();
        snes_wr_req = 1'b1; snes_rom_addr = 24'hE00010; snes_wr_data = 8'h3C;
        step();
        snes_wr_req = 1'b0; snes_rom_addr = '0; snes_wr_data = '0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_drive) drv_cnt++;
            if (!mem_we_n) we_cnt++;
            if (!mem_oe_n) oe_cnt++;
            if (c == 1) begin
                checks++;
                if ({mem_addr, mem_dout} !== {24'hE00010, 8'h3C}) begin
                    errors++;
                    $display("FAIL wr_addr_data got %h/%h exp e00010/3c", mem_addr, mem_dout);
                end
                checks++;
                if (mem_we_n !== 1'b1) begin
                    errors++; $display("FAIL wr_setup got we_n %b exp 1", mem_we_n);
                end
            end
            if (c == 2 || c == 5) begin
                checks++;
                if (mem_we_n !== 1'b0) begin
                    errors++; $display("FAIL wr_strobe cycle %0d got we_n %b exp 0", c, mem_we_n);
                end
            end
            if (c == 6) begin
                checks++;
                if ({mem_we_n, mem_drive} !== 2'b11) begin
                    errors++;
                    $display("FAIL wr_hold got we_n/drive %b%b exp 11", mem_we_n, mem_drive);
                end
            end
            step();
        end
        checks++;
        if ({drv_cnt, we_cnt, oe_cnt} !== {32'd6, 32'd4, 32'd0}) begin
            errors++;
            $display("FAIL wr_counts got drive %0d we %0d oe %0d exp 6 4 0", drv_cnt, we_cnt, oe_cnt);
        end
        $display("test_snes_write: drive %0d we %0d", drv_cnt, we_cnt);
    endtask

    task automatic test_back_to_back();
        int ack_cnt = 0;
        int ack_cycle = -1;
        do_reset();
        dcu_req = 1'b1; dcu_addr = 24'hD01234;
        snes_rd_req = 1'b1; snes_rom_addr = 24'h111111;
        step();
        snes_rd_req = 1'b0; snes_rom_addr = '0;
        for (int c = 1; c <= 20; c++) begin
            mem_din = (c == 6) ? 8'h5A : ((c == 12) ? 8'h77 : 8'h00);
            if (c >= 14) dcu_req = 1'b0;
            if (dcu_ack) begin
                ack_cnt++;
                ack_cycle = c;
            end
            if (c == 1 || c == 7) begin
                checks++;
                if (mem_addr !== ((c == 1) ? 24'h111111 : 24'hD01234) || mem_oe_n !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_window cycle %0d got %h oe_n %b", c, mem_addr, mem_oe_n);
                end
            end
            if (c == 7) begin
                checks++;
                if (snes_rd_data !== 8'h5A) begin
                    errors++; $display("FAIL b2b_snes_data got %h exp 5a", snes_rd_data);
                end
            end
            if (c == 13) begin
                checks++;
                if ({dcu_ack, dcu_data} !== {1'b1, 8'h77}) begin
                    errors++; $display("FAIL b2b_ack got %b/%h exp 1/77", dcu_ack, dcu_data);
                end
                checks++;
                if (mem_oe_n !== 1'b1) begin
                    errors++; $display("FAIL b2b_regrant got oe_n %b exp 1", mem_oe_n);
                end
            end
            step();
        end
        checks++;
        if (ack_cnt != 1 || ack_cycle != 13) begin
            errors++;
            $display("FAIL b2b_ack_count got %0d at %0d exp 1 at 13", ack_cnt, ack_cycle);
        end
        $display("test_back_to_back: dcu_ack at cycle %0d", ack_cycle);
    endtask

    task automatic test_alternate();
        logic [23:0] exp_addr;
        logic        exp_ack;
        do_reset();
        dcu_req = 1'b1; dcu_addr = 24'hD00000;
        for (int c = 0; c <= 37; c++) begin
            snes_rd_req   = (c % 6 == 0) && (c <= 30);
            snes_rom_addr = {8'h50, 16'(c)};
            if (c == 1 || c == 13 || c == 25) begin
                exp_addr = (c == 1) ? 24'h500000 : ((c == 13) ? 24'h50000C : 24'h500018);
                checks++;
                if (mem_addr !== exp_addr) begin
                    errors++; $display("FAIL alt_snes cycle %0d got %h exp %h", c, mem_addr, exp_addr);
                end
            end
            if (c == 7 || c == 19 || c == 31) begin
                checks++;
                if (mem_addr !== 24'hD00000) begin
                    errors++; $display("FAIL alt_dcu cycle %0d got %h exp d00000", c, mem_addr);
                end
            end
            exp_ack = (c == 13) || (c == 25) || (c == 37);
            checks++;
            if (dcu_ack !== exp_ack) begin
                errors++; $display("FAIL alt_ack cycle %0d got %b exp %b", c, dcu_ack, exp_ack);
            end
            step();
        end
        dcu_req = 1'b0; snes_rd_req = 1'b0;
        for (int c = 0; c < 8; c++) step();
        $display("test_alternate: windows S D S D S D checked");
    endtask

    task automatic test_overrun();
        bit saw_first = 1'b0;
        do_reset();
        dcu_req = 1'b1; dcu_addr = 24'hD00000;
        step();
        for (int c = 1; c <= 14; c++) begin
            snes_rd_req   = (c == 2) || (c == 4);
            snes_rom_addr = (c == 2) ? 24'h200002 : 24'h400004;
            if (c >= 8) dcu_req = 1'b0;
            if (!mem_oe_n && mem_addr == 24'h200002) saw_first = 1'b1;
            if (c == 3 || c == 5) begin
                checks++;
                if (snes_overrun !== (c == 5)) begin
                    errors++; $display("FAIL ovr_flag cycle %0d got %b", c, snes_overrun);
                end
            end
            if (c == 7) begin
                checks++;
                if ({mem_addr, mem_oe_n, dcu_ack} !== {24'h400004, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL ovr_second got %h oe_n %b ack %b exp 400004 0 1",
                             mem_addr, mem_oe_n, dcu_ack);
                end
            end
            if (c == 13) begin
                checks++;
                if ({mem_oe_n, snes_overrun, snes_busy} !== 3'b110) begin
                    errors++;
                    $display("FAIL ovr_end got oe_n/ovr/busy %b%b%b exp 110",
                             mem_oe_n, snes_overrun, snes_busy);
                end
            end
            step();
        end
        checks++;
        if (saw_first !== 1'b0) begin
            errors++; $display("FAIL ovr_first_accessed got %b exp 0", saw_first);
        end
        $display("test_overrun: overrun %b", snes_overrun);
    endtask

    task automatic test_snes_refill();
        do_reset();
        snes_rd_req = 1'b1; snes_rom_addr = 24'h000100;
        step();
        for (int c = 1; c <= 8; c++) begin
            snes_rd_req  = 1'b0;
            snes_wr_req  = (c == 3);
            snes_rom_addr = 24'h000200;
            snes_wr_data = 8'h99;
            if (c == 4) begin
                checks++;
                if (snes_busy !== 1'b1) begin
                    errors++; $display("FAIL refill_busy got %b exp 1", snes_busy);
                end
            end
            if (c == 7) begin
                checks++;
                if ({mem_drive, mem_addr, mem_dout} !== {1'b1, 24'h000200, 8'h99}) begin
                    errors++;
                    $display("FAIL refill_write got %b %h %h exp 1 000200 99",
                             mem_drive, mem_addr, mem_dout);
                end
            end
            if (c == 8) begin
                checks++;
                if (snes_overrun !== 1'b0) begin
                    errors++; $display("FAIL refill_overrun got %b exp 0", snes_overrun);
                end
            end
            step();
        end
        snes_wr_req = 1'b0;
        for (int c = 0; c < 6; c++) step();
        $display("test_snes_refill: back-to-back read then write");
    endtask

    task automatic test_reset_mid_window();
        int ack_cycle = -1;
        do_reset();
        dcu_req = 1'b1; dcu_addr = 24'hABCDEF;
        step(); step(); step();
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_oe_n, mem_we_n, mem_drive, snes_busy, dcu_ack, mem_addr} !== {5'b11000, 24'h0}) begin
            errors++;
            $display("FAIL rstmid_async got %b %h exp 11000 000000",
                     {mem_oe_n, mem_we_n, mem_drive, snes_busy, dcu_ack}, mem_addr);
        end
        step();
        rst = 1'b0;
        for (int c = 4; c <= 13; c++) begin
            if (dcu_ack && ack_cycle < 0) ack_cycle = c;
            if (c == 4 || c == 5) begin
                checks++;
                if (mem_oe_n !== (c == 4)) begin
                    errors++; $display("FAIL rstmid_oe cycle %0d got %b", c, mem_oe_n);
                end
            end
            if (c == 12) dcu_req = 1'b0;
            step();
        end
        checks++;
        if (ack_cycle != 11) begin
            errors++; $display("FAIL rstmid_ack got cycle %0d exp 11", ack_cycle);
        end
        $display("test_reset_mid_window: regrant ack at cycle %0d", ack_cycle);
    endtask

    initial begin
        test_reset();
        test_snes_read();
        test_snes_write();
        test_back_to_back();
        test_alternate();
        test_overrun();
        test_snes_refill();
        test_reset_mid_window();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
